// File: rtl/pwm_seq_pkg.sv
// -----------------------------------------------------------------------------
// pwm_seq_pkg
// Shared types and helpers for the PWM duty sequencer.
//   state_t      : sequencer state (IDLE, RAMP, HOLD, FAULT)
//   MAX_W        : widest duty resolution the helpers accept
//   at_least_one : maps a zero field to 1 (step and periods-per-step)
//   step_toward  : one saturating step of a value toward a target
// -----------------------------------------------------------------------------
package pwm_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RAMP  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // Helpers operate on this width; callers zero-extend and truncate back.
   localparam int MAX_W = 32;

   function automatic logic [MAX_W-1:0] at_least_one(input logic [MAX_W-1:0] x);
      return (x == '0) ? MAX_W'(1) : x;
   endfunction

   // Two guard bits keep cur+stp from wrapping and cur-stp from going
   // negative unnoticed; the result is clamped at tgt in either direction.
   function automatic logic [MAX_W-1:0] step_toward(input logic [MAX_W-1:0] cur,
                                                    input logic [MAX_W-1:0] tgt,
                                                    input logic [MAX_W-1:0] stp);
      logic signed [MAX_W+1:0] c;
      logic signed [MAX_W+1:0] t;
      logic signed [MAX_W+1:0] s;
      logic signed [MAX_W+1:0] n;
      c = $signed({2'b00, cur});
      t = $signed({2'b00, tgt});
      s = $signed({2'b00, stp});
      if (t > c) begin
         n = c + s;
         if (n > t) n = t;
      end else begin
         n = c - s;
         if (n < t) n = t;
      end
      return n[MAX_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_period_detect.sv
// -----------------------------------------------------------------------------
// pwm_period_detect
// Finds PWM period boundaries and counts them toward the next duty step.
//   clk, rst : clock, synchronous active-high reset
//   ena      : prescaler enable pulse
//   value    : PWM counter value
//   run      : count boundaries (ramping and sequencer enabled)
//   clr      : clear the period counter (new ramp, fault)
//   pps      : effective periods per step (never 0)
//   boundary : ena high while value is all-ones (counter wraps next advance)
//   tc       : counted boundary that completes a step interval
// -----------------------------------------------------------------------------
module pwm_period_detect
   import pwm_seq_pkg::*;
#(
   parameter int RESOLUTION_BITS = 8,
   parameter int PPS_BITS        = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ena,
   input  logic [RESOLUTION_BITS-1:0] value,
   input  logic                       run,
   input  logic                       clr,
   input  logic [PPS_BITS-1:0]        pps,
   output logic                       boundary,
   output logic                       tc
);

   logic [PPS_BITS-1:0] cnt_q;
   logic [PPS_BITS-1:0] cnt_d;

   assign boundary = ena && (value == '1);
   assign tc       = boundary && run && (cnt_q == (pps - PPS_BITS'(1)));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (boundary && run) begin
         cnt_d = tc ? '0 : (cnt_q + PPS_BITS'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_duty_sequencer
// Soft-start / duty-ramp controller for the PWM comparator reference. Steps
// ref_out toward a loaded target by 'step' every 'periods_per_step' PWM
// periods; updates land only right after a period boundary so the PWM output
// never glitches mid-period.
//   clk, rst         : clock, synchronous active-high reset
//   ena, value       : prescaler enable and PWM counter value (boundary source)
//   enable           : run enable; low freezes the ramp (loads still accepted)
//   load             : start a new ramp (ignored while busy)
//   target, step, periods_per_step : ramp settings, sampled on accepted load
//   fault            : (PWM_SEQ_FAULT_EN only) forces ref_out to 0
//   ref_out          : registered comparator reference
//   busy             : high while ramping
//   done             : one-cycle pulse when ref_out reaches target
// Optional build macro: PWM_SEQ_FAULT_EN adds the fault input and FAULT state.
// -----------------------------------------------------------------------------
module pwm_duty_sequencer
   import pwm_seq_pkg::*;
#(
   parameter int RESOLUTION_BITS = 8,
   parameter int PPS_BITS        = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ena,
   input  logic [RESOLUTION_BITS-1:0] value,
   input  logic                       enable,
   input  logic                       load,
   input  logic [RESOLUTION_BITS-1:0] target,
   input  logic [RESOLUTION_BITS-1:0] step,
   input  logic [PPS_BITS-1:0]        periods_per_step,
`ifdef PWM_SEQ_FAULT_EN
   input  logic                       fault,
`endif
   output logic [RESOLUTION_BITS-1:0] ref_out,
   output logic                       busy,
   output logic                       done
);

   state_t                     state_q, state_d;
   logic [RESOLUTION_BITS-1:0] ref_q, ref_d;
   logic [RESOLUTION_BITS-1:0] tgt_q, tgt_d;
   logic [RESOLUTION_BITS-1:0] step_q, step_d;
   logic [PPS_BITS-1:0]        pps_q, pps_d;
   logic                       done_q, done_d;

   logic                       accept;
   logic                       clr;
   logic                       run;
   logic                       boundary;
   logic                       tc;
   logic [RESOLUTION_BITS-1:0] ref_next;

   assign accept = load && (state_q != ST_RAMP);
   assign run    = enable && (state_q == ST_RAMP);

   pwm_period_detect #(
      .RESOLUTION_BITS (RESOLUTION_BITS),
      .PPS_BITS        (PPS_BITS)
   ) u_period_detect (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .value    (value),
      .run      (run),
      .clr      (clr),
      .pps      (pps_q),
      .boundary (boundary),
      .tc       (tc)
   );

   // Boundary itself only matters through tc; kept visible for debug.
   logic unused_boundary;
   assign unused_boundary = boundary;

   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      tgt_d    = tgt_q;
      step_d   = step_q;
      pps_d    = pps_q;
      done_d   = 1'b0;
      clr      = 1'b0;
      ref_next = RESOLUTION_BITS'(step_toward(MAX_W'(ref_q), MAX_W'(tgt_q), MAX_W'(step_q)));
`ifdef PWM_SEQ_FAULT_EN
      // Fault overrides load and boundary, and blocks loads while asserted.
      if (fault) begin
         state_d = ST_FAULT;
         ref_d   = '0;
         clr     = 1'b1;
      end else
`endif
      if (accept) begin
         // Zero step / periods are stored as 1 so the ramp always advances.
         tgt_d  = target;
         step_d = RESOLUTION_BITS'(at_least_one(MAX_W'(step)));
         pps_d  = PPS_BITS'(at_least_one(MAX_W'(periods_per_step)));
         clr    = 1'b1;
         if (target == ref_q) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
         end else begin
            state_d = ST_RAMP;
         end
      end else if (tc) begin
         ref_d = ref_next;
         if (ref_next == tgt_q) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ref_q   <= '0;
         tgt_q   <= '0;
         step_q  <= '0;
         pps_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         tgt_q   <= tgt_d;
         step_q  <= step_d;
         pps_q   <= pps_d;
         done_q  <= done_d;
      end
   end

   assign ref_out = ref_q;
   assign busy    = (state_q == ST_RAMP);
   assign done    = done_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
`timescale 1ns/1ps
module tb_pwm_duty_sequencer;

   logic       clk = 1'b0;
   logic       rst, ena, enable, load;
   logic [7:0] value, target, step, pps;
   logic [7:0] ref_out;
   logic       busy, done;
   logic       flt;
`ifdef PWM_SEQ_FAULT_EN
   logic       fault;
   assign flt = fault;
`else
   assign flt = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state (plain integers)
   int m_ref, m_tgt, m_stp, m_pps, m_cnt;
   bit m_busy, m_done;
   bit prev_bnd, cur_bnd;

   always #5 clk = ~clk;

   pwm_duty_sequencer #(.RESOLUTION_BITS(8), .PPS_BITS(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .ena              (ena),
      .value            (value),
      .enable           (enable),
      .load             (load),
      .target           (target),
      .step             (step),
      .periods_per_step (pps),
`ifdef PWM_SEQ_FAULT_EN
      .fault            (fault),
`endif
      .ref_out          (ref_out),
      .busy             (busy),
      .done             (done)
   );

   // Behavioural model: what each clock edge should do to the observable state.
   always @(posedge clk) begin
      if (rst) begin
         m_ref = 0; m_tgt = 0; m_stp = 0; m_pps = 0; m_cnt = 0;
         m_busy = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (flt) begin
            m_ref = 0; m_busy = 0; m_cnt = 0;
         end else if (load && !m_busy) begin
            m_tgt = target;
            m_stp = (step == 0) ? 1 : int'(step);
            m_pps = (pps == 0) ? 1 : int'(pps);
            m_cnt = 0;
            if (int'(target) == m_ref) m_done = 1;
            else m_busy = 1;
         end else if (m_busy && enable && ena && value == 8'hFF) begin
            m_cnt++;
            if (m_cnt == m_pps) begin
               m_cnt = 0;
               if (m_tgt > m_ref) m_ref = (m_ref + m_stp > m_tgt) ? m_tgt : m_ref + m_stp;
               else               m_ref = (m_ref - m_stp < m_tgt) ? m_tgt : m_ref - m_stp;
               if (m_ref == m_tgt) begin
                  m_busy = 0;
                  m_done = 1;
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      prev_bnd = cur_bnd;
      ena      = ($urandom_range(0, 3) != 0);
      value    = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      cur_bnd  = ena && (value == 8'hFF);
   endtask

   task automatic test_reset();
      int dones;
      rst = 1'b1; load = 1'b0; enable = 1'b1; target = 8'd0; step = 8'd0; pps = 8'd0;
      tick(); tick();
      checks++;
      if ({ref_out, busy, done} !== 10'd0) begin
         errors++;
         $display("FAIL reset_state ref_out=%0d busy=%0b done=%0b required 0/0/0", ref_out, busy, done);
      end
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         checks++;
         if ({ref_out, busy, done} !== {8'(m_ref), m_busy, m_done}) begin
            errors++;
            $display("FAIL idle_model ref_out=%0d busy=%0b done=%0b required %0d/%0b/%0b", ref_out, busy, done, m_ref, m_busy, m_done);
         end
         if (done) dones++;
      end
      checks++;
      if (dones != 0 || ref_out !== 8'd0) begin
         errors++;
         $display("FAIL idle_quiet done_pulses=%0d ref_out=%0d required 0/0", dones, ref_out);
      end
   endtask

   // Load a ramp and follow it to completion, checking the visible change list
   // and the number of boundaries between successive changes.
   task automatic run_ramp(input string name, input logic [7:0] t, input logic [7:0] s,
                           input logic [7:0] p, input int exp_vals[$], input int bnd_per_step);
      int b, k, dones, prev;
      target = t; step = s; pps = p; load = 1'b1;
      tick();
      load = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s_start busy=%0b done=%0b required 1/0", name, busy, done);
      end
      b = 0; k = 0; dones = 0; prev = ref_out;
      for (int c = 0; c < 3000; c++) begin
         tick();
         checks++;
         if ({ref_out, busy, done} !== {8'(m_ref), m_busy, m_done}) begin
            errors++;
            $display("FAIL %s_model ref_out=%0d busy=%0b done=%0b required %0d/%0b/%0b", name, ref_out, busy, done, m_ref, m_busy, m_done);
         end
         if (prev_bnd) b++;
         if (int'(ref_out) != prev) begin
            checks++;
            if (k >= exp_vals.size() || int'(ref_out) != exp_vals[k] || b != bnd_per_step * (k + 1)) begin
               errors++;
               $display("FAIL %s_step%0d ref_out=%0d after %0d boundaries required %0d after %0d", name, k, ref_out, b,
                        (k < exp_vals.size()) ? exp_vals[k] : -1, bnd_per_step * (k + 1));
            end
            k++;
            prev = ref_out;
         end
         if (done) begin
            dones++;
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL %s_busy_with_done busy=%0b required 0", name, busy);
            end
            break;
         end
      end
      tick();
      checks++;
      if (dones != 1 || k != exp_vals.size() || done !== 1'b0 || ref_out !== t) begin
         errors++;
         $display("FAIL %s_end done_pulses=%0d steps=%0d done=%0b ref_out=%0d required 1/%0d/0/%0d", name, dones, k, done, ref_out, exp_vals.size(), t);
      end
   endtask

   task automatic test_ramp_up();
      run_ramp("ramp_up", 8'd100, 8'd10, 8'd2, '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100}, 2);
   endtask

   task automatic test_ramp_down();
      run_ramp("ramp_down", 8'd5, 8'd30, 8'd1, '{70, 40, 10, 5}, 1);
   endtask

   task automatic test_zero_fields();
      run_ramp("zero_fields", 8'd3, 8'd0, 8'd0, '{1, 2, 3}, 1);
   endtask

   task automatic test_equal_and_busy_load();
      int dones;
      target = 8'd5; step = 8'd9; pps = 8'd3; load = 1'b1;
      tick();
      load = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || ref_out !== 8'd5) begin
         errors++;
         $display("FAIL equal_load done=%0b busy=%0b ref_out=%0d required 1/0/5", done, busy, ref_out);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL equal_load_pulse done=%0b busy=%0b required 0/0", done, busy);
      end
      target = 8'd50; step = 8'd5; pps = 8'd4; load = 1'b1;
      tick();
      load = 1'b0;
      dones = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         load = (c >= 3 && c < 6);
         target = 8'd0; step = 8'd200; pps = 8'd1;
         checks++;
         if ({ref_out, busy, done} !== {8'(m_ref), m_busy, m_done}) begin
            errors++;
            $display("FAIL busy_load_model ref_out=%0d busy=%0b done=%0b required %0d/%0b/%0b", ref_out, busy, done, m_ref, m_busy, m_done);
         end
         if (done) begin
            dones++;
            break;
         end
      end
      load = 1'b0;
      checks++;
      if (dones != 1 || ref_out !== 8'd50) begin
         errors++;
         $display("FAIL busy_load_ignored done_pulses=%0d ref_out=%0d required 1/50", dones, ref_out);
      end
   endtask

   task automatic test_freeze();
      int b;
      target = 8'd0; step = 8'd10; pps = 8'd2; load = 1'b1;
      tick();
      load = 1'b0;
      for (int c = 0; c < 2000 && ref_out == 8'd50; c++) tick();
      checks++;
      if (ref_out !== 8'd40) begin
         errors++;
         $display("FAIL freeze_first_step ref_out=%0d required 40", ref_out);
      end
      enable = 1'b0;
      b = 0;
      for (int c = 0; c < 2000 && b < 4; c++) begin
         tick();
         if (prev_bnd) b++;
         checks++;
         if (ref_out !== 8'd40 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL freeze_hold ref_out=%0d busy=%0b done=%0b required 40/1/0", ref_out, busy, done);
         end
      end
      enable = 1'b1;
      for (int c = 0; c < 3000 && m_ref != 0; c++) begin
         tick();
         checks++;
         if ({ref_out, busy, done} !== {8'(m_ref), m_busy, m_done}) begin
            errors++;
            $display("FAIL freeze_resume_model ref_out=%0d busy=%0b done=%0b required %0d/%0b/%0b", ref_out, busy, done, m_ref, m_busy, m_done);
         end
      end
      tick();
      checks++;
      if (ref_out !== 8'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL freeze_end ref_out=%0d busy=%0b required 0/0", ref_out, busy);
      end
   endtask

   task automatic test_reset_mid();
      target = 8'd200; step = 8'd1; pps = 8'd1; load = 1'b1;
      tick();
      load = 1'b0;
      repeat (20) tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({ref_out, busy, done} !== 10'd0) begin
         errors++;
         $display("FAIL reset_mid ref_out=%0d busy=%0b done=%0b required 0/0/0", ref_out, busy, done);
      end
      rst = 1'b0;
      repeat (10) tick();
      checks++;
      if ({ref_out, busy, done} !== 10'd0) begin
         errors++;
         $display("FAIL reset_mid_after ref_out=%0d busy=%0b done=%0b required 0/0/0", ref_out, busy, done);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 30; it++) begin
         target = 8'($urandom_range(0, 255));
         step   = 8'($urandom_range(0, 63));
         pps    = 8'($urandom_range(0, 3));
         load   = 1'b1;
         for (int c = 0; c < 150; c++) begin
            tick();
            load = ($urandom_range(0, 31) == 0);
            if (load) begin
               target = 8'($urandom_range(0, 255));
               step   = 8'($urandom_range(0, 63));
               pps    = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            checks++;
            if ({ref_out, busy, done} !== {8'(m_ref), m_busy, m_done}) begin
               errors++;
               $display("FAIL random_model it=%0d ref_out=%0d busy=%0b done=%0b required %0d/%0b/%0b", it, ref_out, busy, done, m_ref, m_busy, m_done);
            end
         end
      end
      load = 1'b0;
      enable = 1'b1;
   endtask

`ifdef PWM_SEQ_FAULT_EN
   task automatic test_fault();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      target = 8'd100; step = 8'd20; pps = 8'd1; load = 1'b1;
      tick();
      load = 1'b0;
      for (int c = 0; c < 2000 && ref_out != 8'd60; c++) tick();
      checks++;
      if (ref_out !== 8'd60) begin
         errors++;
         $display("FAIL fault_reach60 ref_out=%0d required 60", ref_out);
      end
      fault = 1'b1;
      tick();
      checks++;
      if ({ref_out, busy, done} !== 10'd0) begin
         errors++;
         $display("FAIL fault_entry ref_out=%0d busy=%0b done=%0b required 0/0/0", ref_out, busy, done);
      end
      target = 8'd90; load = 1'b1;
      repeat (4) begin
         tick();
         checks++;
         if ({ref_out, busy, done} !== 10'd0) begin
            errors++;
            $display("FAIL fault_load_blocked ref_out=%0d busy=%0b done=%0b required 0/0/0", ref_out, busy, done);
         end
      end
      load = 1'b0;
      fault = 1'b0;
      tick();
      run_ramp("fault_recover", 8'd40, 8'd20, 8'd1, '{20, 40}, 1);
   endtask
`endif

   initial begin
      rst = 1'b1; ena = 1'b0; value = 8'd0; enable = 1'b1; load = 1'b0;
      target = 8'd0; step = 8'd0; pps = 8'd0;
      prev_bnd = 1'b0; cur_bnd = 1'b0;
`ifdef PWM_SEQ_FAULT_EN
      fault = 1'b0;
`endif
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_equal_and_busy_load();
      test_freeze();
      test_zero_fields();
      test_reset_mid();
      test_random();
`ifdef PWM_SEQ_FAULT_EN
      test_fault();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
